// File: rtl/ras_pkg.sv
// ras_pkg: op encodings, FSM state type and widths shared by the return-address-stack controller.
package ras_pkg;
  localparam int DEPTH_DEF = 16;
  localparam int PTR_W = 4;
  localparam int CNT_W = 5;
  typedef enum logic [1:0] {OP_NOOP = 2'b00, OP_PUSH = 2'b01, OP_POP = 2'b10, OP_POPPUSH = 2'b11} ras_op_t;
  typedef enum logic {IDLE = 1'b0, REPAIR = 1'b1} ras_state_t;
endpackage

// File: rtl/ras_ctrl.sv
// ras_ctrl: return-address-stack pointer/occupancy control with flush checkpoint restore and one-cycle repair write.
module ras_ctrl
  import ras_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall_i,
  input  logic               req_vld_f1_i,
  input  logic [1:0]         req_op_f1_i,
  input  logic [AW-1:0]      req_dat_f1_i,
  input  logic               flush_i,
  input  logic [PTR_W-1:0]   flush_ptr_i,
  input  logic [CNT_W-1:0]   flush_cnt_i,
  input  logic               flush_repair_i,
  input  logic [AW-1:0]      flush_dat_i,
  output logic               ram_we_o,
  output logic [PTR_W-1:0]   ram_idx_o,
  output logic [AW-1:0]      ram_wdat_o,
  output logic [PTR_W-1:0]   ras_ptr_o,
  output logic [CNT_W-1:0]   ras_cnt_o,
  output logic               busy_o,
  output logic               uflow_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  ras_state_t state, state_nx;
  logic [PTR_W-1:0] ptr, ptr_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [AW-1:0] dat, dat_nx;
  logic we, we_nx, uf, uf_nx, accept;
  ras_op_t op;
  assign op = ras_op_t'(req_op_f1_i);
  assign accept = req_vld_f1_i & ~stall_i & ~flush_i & (state == IDLE);
  always_comb begin
    state_nx = IDLE;
    ptr_nx = ptr;
    cnt_nx = cnt;
    dat_nx = dat;
    we_nx = 1'b0;
    uf_nx = 1'b0;
    if (flush_i) begin
      ptr_nx = flush_ptr_i;
      cnt_nx = (flush_cnt_i > CNT_MAX) ? CNT_MAX : flush_cnt_i;
      if (flush_repair_i) begin
        dat_nx = flush_dat_i;
        we_nx = 1'b1;
        state_nx = REPAIR;
      end
    end else if (accept) begin
      case (op)
        OP_PUSH: begin
          ptr_nx = ptr + 1'b1;
          cnt_nx = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
          dat_nx = req_dat_f1_i;
          we_nx = 1'b1;
        end
        OP_POP: begin
          uf_nx = (cnt == '0);
          ptr_nx = (cnt == '0) ? ptr : ptr - 1'b1;
          cnt_nx = (cnt == '0) ? cnt : cnt - 1'b1;
        end
        OP_POPPUSH: begin
          cnt_nx = (cnt == '0) ? CNT_W'(1) : cnt;
          dat_nx = req_dat_f1_i;
          we_nx = 1'b1;
        end
        default: ;
      endcase
    end
  end
  // The write data register doubles as the captured repair data, so the REPAIR cycle needs no extra mux.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      dat <= '0;
      we <= 1'b0;
      uf <= 1'b0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      cnt <= cnt_nx;
      dat <= dat_nx;
      we <= we_nx;
      uf <= uf_nx;
    end
  end
  assign ram_we_o = we;
  assign ram_idx_o = ptr;
  assign ram_wdat_o = dat;
  assign ras_ptr_o = ptr;
  assign ras_cnt_o = cnt;
  assign busy_o = (state == REPAIR);
  assign uflow_o = uf;
endmodule

// File: tb/tb_ras_ctrl.sv
// tb_ras_ctrl: directed scenarios plus randomized traffic checked against a behavioural stack model.
module tb_ras_ctrl;
  localparam int AW = 64;
  logic clock = 0, reset = 1, stall_i = 0, req_vld_f1_i = 0, flush_i = 0, flush_repair_i = 0;
  logic [1:0] req_op_f1_i = 0;
  logic [AW-1:0] req_dat_f1_i = 0, flush_dat_i = 0;
  logic [3:0] flush_ptr_i = 0;
  logic [4:0] flush_cnt_i = 0;
  logic ram_we_o, busy_o, uflow_o;
  logic [3:0] ram_idx_o, ras_ptr_o;
  logic [AW-1:0] ram_wdat_o;
  logic [4:0] ras_cnt_o;
  int total = 0, bad = 0;
  int m_ptr = 0, m_cnt = 0;
  bit m_rep = 0, e_we = 0, e_uf = 0;
  logic [AW-1:0] m_dat = 0;

  ras_ctrl #(.DEPTH(16), .AW(AW)) dut (
    .clock(clock), .reset(reset), .stall_i(stall_i), .req_vld_f1_i(req_vld_f1_i),
    .req_op_f1_i(req_op_f1_i), .req_dat_f1_i(req_dat_f1_i), .flush_i(flush_i),
    .flush_ptr_i(flush_ptr_i), .flush_cnt_i(flush_cnt_i), .flush_repair_i(flush_repair_i),
    .flush_dat_i(flush_dat_i), .ram_we_o(ram_we_o), .ram_idx_o(ram_idx_o),
    .ram_wdat_o(ram_wdat_o), .ras_ptr_o(ras_ptr_o), .ras_cnt_o(ras_cnt_o),
    .busy_o(busy_o), .uflow_o(uflow_o)
  );

  always #5 clock = ~clock;

  task automatic idle_inputs();
    stall_i = 0; req_vld_f1_i = 0; req_op_f1_i = 0; req_dat_f1_i = 0;
    flush_i = 0; flush_ptr_i = 0; flush_cnt_i = 0; flush_repair_i = 0; flush_dat_i = 0;
  endtask

  task automatic step();
    bit acc;
    e_we = 0; e_uf = 0;
    if (flush_i) begin
      m_ptr = int'(flush_ptr_i);
      m_cnt = (int'(flush_cnt_i) > 16) ? 16 : int'(flush_cnt_i);
      m_rep = flush_repair_i;
      if (flush_repair_i) begin e_we = 1; m_dat = flush_dat_i; end
    end else begin
      acc = req_vld_f1_i && !stall_i && !m_rep;
      m_rep = 0;
      if (acc) begin
        if (req_op_f1_i == 2'd1) begin
          m_ptr = (m_ptr + 1) % 16; m_cnt = (m_cnt < 16) ? m_cnt + 1 : 16;
          e_we = 1; m_dat = req_dat_f1_i;
        end else if (req_op_f1_i == 2'd2) begin
          if (m_cnt == 0) e_uf = 1;
          else begin m_ptr = (m_ptr + 15) % 16; m_cnt = m_cnt - 1; end
        end else if (req_op_f1_i == 2'd3) begin
          m_cnt = (m_cnt == 0) ? 1 : m_cnt; e_we = 1; m_dat = req_dat_f1_i;
        end
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    m_ptr = 0; m_cnt = 0; m_rep = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clock); #1;
    total++;
    if ({ram_we_o, ram_idx_o, ram_wdat_o, ras_ptr_o, ras_cnt_o, busy_o, uflow_o} !== '0) begin
      bad++; $display("FAIL reset_outputs: got we=%0b idx=%0d wdat=%0h ptr=%0d cnt=%0d busy=%0b uf=%0b want all 0",
        ram_we_o, ram_idx_o, ram_wdat_o, ras_ptr_o, ras_cnt_o, busy_o, uflow_o);
    end
    reset = 0;
    m_ptr = 0; m_cnt = 0; m_rep = 0;
  endtask

  task automatic test_push3();
    logic [AW-1:0] v [3] = '{64'h100, 64'h200, 64'h300};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req_vld_f1_i = 1; req_op_f1_i = 2'd1; req_dat_f1_i = v[i];
      step();
      total++;
      if (ram_we_o !== 1'b1 || ram_idx_o !== 4'(i + 1) || ram_wdat_o !== v[i] || ras_ptr_o !== 4'(i + 1)) begin
        bad++; $display("FAIL push3_%0d: got we=%0b idx=%0d wdat=%0h ptr=%0d want we=1 idx=%0d wdat=%0h",
          i, ram_we_o, ram_idx_o, ram_wdat_o, ras_ptr_o, i + 1, v[i]);
      end
    end
    idle_inputs();
    step();
    total++;
    if (ras_cnt_o !== 5'd3 || ras_ptr_o !== 4'd3 || ram_we_o !== 1'b0) begin
      bad++; $display("FAIL push3_final: got cnt=%0d ptr=%0d we=%0b want cnt=3 ptr=3 we=0", ras_cnt_o, ras_ptr_o, ram_we_o);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      req_vld_f1_i = 1; req_op_f1_i = 2'd1; req_dat_f1_i = AW'(i + 1);
      step();
      if (i == 15) begin
        total++;
        if (ras_ptr_o !== 4'd0 || ras_cnt_o !== 5'd16) begin
          bad++; $display("FAIL wrap_16th: got ptr=%0d cnt=%0d want ptr=0 cnt=16", ras_ptr_o, ras_cnt_o);
        end
      end
    end
    total++;
    if (ram_we_o !== 1'b1 || ram_idx_o !== 4'd1 || ras_cnt_o !== 5'd16 || ram_wdat_o !== AW'(17)) begin
      bad++; $display("FAIL wrap_17th: got we=%0b idx=%0d cnt=%0d wdat=%0h want we=1 idx=1 cnt=16 wdat=11",
        ram_we_o, ram_idx_o, ras_cnt_o, ram_wdat_o);
    end
    idle_inputs();
  endtask

  task automatic test_uflow();
    do_reset();
    req_vld_f1_i = 1; req_op_f1_i = 2'd2;
    step();
    total++;
    if (uflow_o !== 1'b1 || ram_we_o !== 1'b0 || ras_ptr_o !== 4'd0 || ras_cnt_o !== 5'd0) begin
      bad++; $display("FAIL uflow_pulse: got uf=%0b we=%0b ptr=%0d cnt=%0d want uf=1 we=0 ptr=0 cnt=0",
        uflow_o, ram_we_o, ras_ptr_o, ras_cnt_o);
    end
    idle_inputs();
    step();
    total++;
    if (uflow_o !== 1'b0) begin bad++; $display("FAIL uflow_clear: got uf=%0b want 0", uflow_o); end
  endtask

  task automatic test_flush_repair();
    do_reset();
    req_vld_f1_i = 1; req_op_f1_i = 2'd1; req_dat_f1_i = 64'h777;
    flush_i = 1; flush_ptr_i = 5; flush_cnt_i = 4; flush_repair_i = 1; flush_dat_i = 64'hABC;
    step();
    total++;
    if (ras_ptr_o !== 4'd5 || ras_cnt_o !== 5'd4 || busy_o !== 1'b1 || ram_we_o !== 1'b1 ||
        ram_idx_o !== 4'd5 || ram_wdat_o !== 64'hABC) begin
      bad++; $display("FAIL repair_write: got ptr=%0d cnt=%0d busy=%0b we=%0b idx=%0d wdat=%0h want 5 4 1 1 5 abc",
        ras_ptr_o, ras_cnt_o, busy_o, ram_we_o, ram_idx_o, ram_wdat_o);
    end
    req_vld_f1_i = 0; flush_ptr_i = 9; flush_cnt_i = 2; flush_repair_i = 0;
    step();
    total++;
    if (ram_we_o !== 1'b0 || ras_ptr_o !== 4'd9 || busy_o !== 1'b0 || ram_idx_o !== 4'd9 || ras_cnt_o !== 5'd2) begin
      bad++; $display("FAIL repair_abandon: got we=%0b ptr=%0d busy=%0b idx=%0d cnt=%0d want 0 9 0 9 2",
        ram_we_o, ras_ptr_o, busy_o, ram_idx_o, ras_cnt_o);
    end
    flush_ptr_i = 5; flush_cnt_i = 4; flush_repair_i = 1; flush_dat_i = 64'hDEF;
    step();
    flush_i = 0; flush_repair_i = 0;
    req_vld_f1_i = 1; req_op_f1_i = 2'd1; req_dat_f1_i = 64'h999;
    step();
    total++;
    if (busy_o !== 1'b0 || ram_we_o !== 1'b0 || ras_ptr_o !== 4'd5 || ras_cnt_o !== 5'd4) begin
      bad++; $display("FAIL repair_done: got busy=%0b we=%0b ptr=%0d cnt=%0d want 0 0 5 4",
        busy_o, ram_we_o, ras_ptr_o, ras_cnt_o);
    end
    idle_inputs();
  endtask

  task automatic test_poppush();
    do_reset();
    flush_i = 1; flush_ptr_i = 2; flush_cnt_i = 0;
    step();
    idle_inputs();
    req_vld_f1_i = 1; req_op_f1_i = 2'd3; req_dat_f1_i = 64'h55;
    step();
    total++;
    if (ram_we_o !== 1'b1 || ram_idx_o !== 4'd2 || ras_ptr_o !== 4'd2 || ras_cnt_o !== 5'd1 || ram_wdat_o !== 64'h55) begin
      bad++; $display("FAIL poppush_empty: got we=%0b idx=%0d ptr=%0d cnt=%0d wdat=%0h want 1 2 2 1 55",
        ram_we_o, ram_idx_o, ras_ptr_o, ras_cnt_o, ram_wdat_o);
    end
    idle_inputs();
  endtask

  task automatic test_flush_sat_stall();
    do_reset();
    flush_i = 1; flush_ptr_i = 7; flush_cnt_i = 5'd31;
    step();
    total++;
    if (ras_cnt_o !== 5'd16 || ras_ptr_o !== 4'd7) begin
      bad++; $display("FAIL flush_sat: got cnt=%0d ptr=%0d want 16 7", ras_cnt_o, ras_ptr_o);
    end
    idle_inputs();
    stall_i = 1; req_vld_f1_i = 1; req_op_f1_i = 2'd1;
    step();
    total++;
    if (ram_we_o !== 1'b0 || ras_ptr_o !== 4'd7) begin
      bad++; $display("FAIL stall_drop: got we=%0b ptr=%0d want 0 7", ram_we_o, ras_ptr_o);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_repair();
    do_reset();
    flush_i = 1; flush_ptr_i = 3; flush_cnt_i = 3; flush_repair_i = 1; flush_dat_i = 64'h1234;
    step();
    idle_inputs();
    #2 reset = 1;
    #1;
    total++;
    if (ram_we_o !== 1'b0 || busy_o !== 1'b0 || ras_ptr_o !== 4'd0 || ram_wdat_o !== '0) begin
      bad++; $display("FAIL reset_async: got we=%0b busy=%0b ptr=%0d wdat=%0h want 0 0 0 0",
        ram_we_o, busy_o, ras_ptr_o, ram_wdat_o);
    end
    @(posedge clock); #1;
    reset = 0;
    m_ptr = 0; m_cnt = 0; m_rep = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      stall_i = ($urandom_range(0, 7) == 0);
      req_vld_f1_i = ($urandom_range(0, 3) != 0);
      req_op_f1_i = 2'($urandom);
      req_dat_f1_i = {$urandom, $urandom};
      flush_i = ($urandom_range(0, 11) == 0);
      flush_ptr_i = 4'($urandom);
      flush_cnt_i = 5'($urandom);
      flush_repair_i = 1'($urandom);
      flush_dat_i = {$urandom, $urandom};
      step();
      total++;
      if (ras_ptr_o !== 4'(m_ptr) || ras_cnt_o !== 5'(m_cnt) || busy_o !== m_rep || ram_we_o !== e_we ||
          ram_idx_o !== 4'(m_ptr) || uflow_o !== e_uf || (e_we && ram_wdat_o !== m_dat)) begin
        bad++; $display("FAIL random_%0d: got ptr=%0d cnt=%0d busy=%0b we=%0b idx=%0d uf=%0b wdat=%0h want %0d %0d %0b %0b %0d %0b %0h",
          i, ras_ptr_o, ras_cnt_o, busy_o, ram_we_o, ram_idx_o, uflow_o, ram_wdat_o,
          m_ptr, m_cnt, m_rep, e_we, m_ptr, e_uf, m_dat);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_push3();
    test_wrap();
    test_uflow();
    test_flush_repair();
    test_poppush();
    test_flush_sat_stall();
    test_reset_mid_repair();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ras_ctrl.md
RAS_CTRL -- requirements
Module: ras_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of stack entries (power of two).
REQ-002 SHALL have parameter AW, default 64, meaning return-address width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset; there is no other clock or reset.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 stall_i  input  1  fetch stall; suppresses request acceptance.
REQ-007 req_vld_f1_i  input  1  f1 stack request valid.
REQ-008 req_op_f1_i  input  2  op: 00 NOOP, 01 PUSH, 10 POP, 11 POPPUSH.
REQ-009 req_dat_f1_i  input  AW  return address to push.
REQ-010 flush_i  input  1  backend redirect; restore checkpoint.
REQ-011 flush_ptr_i  input  4  checkpointed TOS pointer.
REQ-012 flush_cnt_i  input  5  checkpointed occupancy.
REQ-013 flush_repair_i  input  1  rewrite the entry at flush_ptr_i.
REQ-014 flush_dat_i  input  AW  repair data.
REQ-015 ram_we_o  output  1  stack RAM write enable.
REQ-016 ram_idx_o  output  4  stack RAM index (write, and read of TOS when ram_we_o low).
REQ-017 ram_wdat_o  output  AW  stack RAM write data.
REQ-018 ras_ptr_o  output  4  current TOS pointer, checkpointed by bob.
REQ-019 ras_cnt_o  output  5  occupancy, 0..16.
REQ-020 busy_o  output  1  high in REPAIR; requests ignored.
REQ-021 uflow_o  output  1  one-cycle pulse on POP while empty.

Function
REQ-022 SHALL accept a request in cycle N when req_vld_f1_i & ~stall_i & ~flush_i & ~busy_o; all other requests are dropped, not queued.
REQ-023 SHALL register all outputs; the effects of a request accepted in cycle N become visible in cycle N+1.
REQ-024 PUSH SHALL set ptr=(ptr+1) mod 16, write req_dat at the new ptr, and set cnt=min(cnt+1,16).
REQ-025 A PUSH at full SHALL wrap, overwriting the oldest entry, with cnt held at 16.
REQ-026 POP SHALL set ptr=(ptr-1) mod 16 and cnt=cnt-1, with no RAM write.
REQ-027 A POP at cnt=0 SHALL leave ptr and cnt unchanged and pulse uflow_o in N+1.
REQ-028 POPPUSH SHALL write req_dat at the current ptr, leave ptr unchanged, and set cnt=max(cnt,1).
REQ-029 NOOP SHALL leave all state unchanged, and ram_we_o SHALL be 0.
REQ-030 ram_we_o SHALL be high for exactly one cycle per PUSH, POPPUSH or repair.
REQ-031 When ram_we_o is 0, ram_idx_o SHALL equal ras_ptr_o.
REQ-032 FSM SHALL have two states, IDLE and REPAIR.
REQ-033 IDLE + flush_i & ~flush_repair_i SHALL load ptr=flush_ptr_i and cnt=flush_cnt_i and stay in IDLE.
REQ-034 IDLE + flush_i & flush_repair_i SHALL load ptr/cnt, capture flush_dat_i, and go to REPAIR.
REQ-035 REPAIR SHALL last exactly one cycle: ram_we_o=1, ram_idx_o=ptr, ram_wdat_o=captured data, busy_o=1; it then returns to IDLE.
REQ-036 flush_i SHALL have priority over a simultaneous request; the request is dropped.
REQ-037 flush_i arriving in REPAIR SHALL abandon the current repair and apply REQ-033/034 with the new values.
REQ-038 flush_cnt_i values above 16 SHALL saturate to 16.
REQ-039 All pointer arithmetic SHALL be 4-bit modulo; count arithmetic SHALL be 5-bit with saturation.

Reset
REQ-040 Reset SHALL asynchronously force state IDLE, ptr=0, cnt=0, and captured data=0.
REQ-041 During reset, ram_we_o=0, ram_idx_o=0, ram_wdat_o=0, busy_o=0 and uflow_o=0.
REQ-042 Reset asserted mid-REPAIR SHALL abort the write; the RAM contents are not restored.

Structure
REQ-043 Package ras_pkg SHALL hold the op encodings (NOOP/PUSH/POP/POPPUSH), the FSM state type, DEPTH_DEF=16 and the pointer/count widths.
REQ-044 ras_ctrl SHALL contain no sub-module; the parent instantiates the stack RAM (ram_sp) and connects it to the ram_* ports.
REQ-045 ras_ctrl SHALL hold no stack data storage.

Verification
REQ-046 Reset, then 3 PUSHes of 0x100/0x200/0x300 -> ptr 1,2,3; cnt 3; writes at idx 1,2,3 carrying those values.
REQ-047 17 PUSHes from empty -> ptr wraps 15->0; cnt saturates at 16; the 17th write lands at idx 1.
REQ-048 POP at cnt=0 -> ptr 0 and cnt 0 unchanged; uflow_o pulses for one cycle; ram_we_o stays 0.
REQ-049 PUSH with flush_i (ptr 5, cnt 4, repair 0xABC) in the same cycle -> push dropped; next cycle ptr 5, cnt 4, busy_o 1, write 0xABC at idx 5; then IDLE.
REQ-050 Second flush (ptr 9, no repair) during REPAIR -> no write at idx 5; ptr 9; busy_o 0 in the next cycle.
REQ-051 POPPUSH at cnt=0, ptr=2 -> write at idx 2; ptr stays 2; cnt 1.
